// File: rtl/periph_uart_pkg.sv
// Shared constants and state encoding for the UART streamer.
// Holds the register map, status bit indices and FSM states.
package periph_uart_pkg;

    localparam logic [31:0] STAT_ADDR = 32'h4000_0020;
    localparam logic [31:0] RXD_ADDR  = 32'h4000_001C;
    localparam logic [31:0] TXD_ADDR  = 32'h4000_0018;

    localparam int STAT_TX_IDLE = 0;
    localparam int STAT_RX_PEND = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_RX_READ,
        ST_TX_WRITE,
        ST_GUARD
    } state_t;

endpackage

// File: rtl/periph_uart_streamer_fifo.sv
// byte_fifo: synchronous 8-bit FIFO with registered pointers.
// Ports: clk, reset, push/push_data, pop, head, full, empty.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [7:0]  mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    // A pop frees the slot, so a push while full is taken
    // in the same cycle as a pop.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + (AW+1)'(1);
            if (pop_ok)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/periph_uart_streamer.sv
// Bus initiator that feeds pushed bytes to the UART TXD register
// and drains RXD. Ports: push_*, rd/wr/addr/wdata/rdata bus,
// rx_valid/rx_data strobe, busy.
module periph_uart_streamer
    import periph_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TX_GUARD   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_valid,
    input  logic [7:0]  push_data,
    output logic        push_ready,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        busy
);

    localparam int GW = $clog2(TX_GUARD + 1);

    state_t        state;
    state_t        state_next;
    logic [GW-1:0] guard_cnt;
    logic [GW-1:0] guard_next;
    logic [31:0]   addr_next;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          unused_rdata;

    assign unused_rdata = ^rdata[31:8];
    assign fifo_pop     = (state == ST_TX_WRITE);
    assign push_ready   = !fifo_full;
    assign busy         = !fifo_empty || (state != ST_IDLE);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_valid),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next = state;
        guard_next = guard_cnt;
        unique case (state)
            ST_IDLE:
                state_next = ST_POLL;
            ST_POLL: begin
                if (rdata[STAT_RX_PEND])
                    state_next = ST_RX_READ;
                else if (rdata[STAT_TX_IDLE] && !fifo_empty)
                    state_next = ST_TX_WRITE;
            end
            ST_RX_READ:
                state_next = ST_POLL;
            ST_TX_WRITE: begin
                guard_next = GW'(TX_GUARD);
                state_next = ST_GUARD;
            end
            ST_GUARD: begin
                guard_next = guard_cnt - GW'(1);
                if (guard_next == '0)
                    state_next = ST_POLL;
            end
            default:
                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_next = '0;
        unique case (state_next)
            ST_POLL:     addr_next = STAT_ADDR;
            ST_RX_READ:  addr_next = RXD_ADDR;
            ST_TX_WRITE: addr_next = TXD_ADDR;
            default:     addr_next = '0;
        endcase
    end

    // Bus outputs are registered from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            guard_cnt <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
        end else begin
            state     <= state_next;
            guard_cnt <= guard_next;
            rd        <= (state_next == ST_POLL) ||
                         (state_next == ST_RX_READ);
            wr        <= (state_next == ST_TX_WRITE);
            addr      <= addr_next;
            wdata     <= (state_next == ST_TX_WRITE) ?
                         {24'b0, fifo_head} : 32'b0;
            rx_valid  <= (state == ST_RX_READ);
            if (state == ST_RX_READ)
                rx_data <= rdata[7:0];
        end
    end

endmodule

// File: tb/tb_periph_uart_streamer.sv
// Self-checking bench for periph_uart_streamer with a UART
// register responder and queue-based expected byte streams.
module tb_periph_uart_streamer;

    localparam int DEPTH = 16;
    localparam int GUARD = 4;
    localparam logic [31:0] A_STAT = 32'h4000_0020;
    localparam logic [31:0] A_RXD  = 32'h4000_001C;
    localparam logic [31:0] A_TXD  = 32'h4000_0018;

    logic        clk = 0;
    logic        reset = 1;
    logic        push_valid = 0;
    logic [7:0]  push_data = 0;
    logic        push_ready;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        busy;

    logic        tx_idle = 0;
    logic        rx_pending = 0;
    logic [7:0]  rx_byte = 0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bus_viol = 0;

    logic [7:0] wq[$];
    int         wcyc[$];
    logic [7:0] rxq[$];
    int         rxcyc[$];
    int         rdcyc[$];

    periph_uart_streamer #(
        .FIFO_DEPTH (DEPTH),
        .TX_GUARD   (GUARD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART register responder
    always_comb begin
        rdata = 32'h0;
        if (rd && addr == A_STAT)
            rdata = {30'b0, rx_pending, tx_idle};
        else if (rd && addr == A_RXD)
            rdata = {24'b0, rx_byte};
    end

    // Bus observer
    always @(negedge clk) begin
        if (rd && wr) bus_viol++;
        if (!rd && !wr && (addr != 0 || wdata != 0))
            bus_viol++;
        if (wr && (addr != A_TXD || wdata[31:8] != 0))
            bus_viol++;
        if (rd && addr != A_STAT && addr != A_RXD)
            bus_viol++;
        if (wr) begin
            wq.push_back(wdata[7:0]);
            wcyc.push_back(cyc);
        end
        if (rd && addr == A_RXD) begin
            rx_pending = 0;
            rdcyc.push_back(cyc);
        end
        if (rx_valid) begin
            rxq.push_back(rx_data);
            rxcyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        push_valid = 0;
        tx_idle = 0;
        rx_pending = 0;
        @(negedge clk);
        reset = 0;
        wq.delete();
        wcyc.delete();
        rxq.delete();
        rxcyc.delete();
        rdcyc.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1;
        @(negedge clk);
        total += 8;
        if (rd !== 0) begin
            bad++; $display("FAIL rst_rd got=%0b exp=0", rd);
        end
        if (wr !== 0) begin
            bad++; $display("FAIL rst_wr got=%0b exp=0", wr);
        end
        if (addr !== 0) begin
            bad++; $display("FAIL rst_addr got=%h exp=0", addr);
        end
        if (wdata !== 0) begin
            bad++; $display("FAIL rst_wdata got=%h exp=0", wdata);
        end
        if (rx_valid !== 0) begin
            bad++; $display("FAIL rst_rxv got=%0b exp=0", rx_valid);
        end
        if (rx_data !== 0) begin
            bad++; $display("FAIL rst_rxd got=%h exp=0", rx_data);
        end
        if (busy !== 0) begin
            bad++; $display("FAIL rst_busy got=%0b exp=0", busy);
        end
        if (push_ready !== 1) begin
            bad++;
            $display("FAIL rst_ready got=%0b exp=1", push_ready);
        end
        reset = 0;
    endtask

    task automatic test_tx_basic();
        logic [7:0] exp[$];
        int n;
        int pc;
        do_reset();
        tx_idle = 1;
        exp.push_back(8'h41);
        exp.push_back(8'h42);
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++)
            exp.push_back(8'($urandom));
        for (int i = 0; i < exp.size(); i++) begin
            @(negedge clk);
            if (i == 0) pc = cyc;
            push_valid = 1;
            push_data = exp[i];
        end
        @(negedge clk);
        push_valid = 0;
        for (int i = 0; i < 300 && wq.size() < exp.size(); i++)
            @(negedge clk);
        total++;
        if (wq.size() !== exp.size()) begin
            bad++;
            $display("FAIL tx_count got=%0d exp=%0d",
                     wq.size(), exp.size());
        end else begin
            total++;
            if (wcyc[0] - pc < 2) begin
                bad++;
                $display("FAIL tx_first_lat got=%0d exp>=2",
                         wcyc[0] - pc);
            end
            for (int i = 0; i < exp.size(); i++) begin
                total++;
                if (wq[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL tx_data[%0d] got=%h exp=%h",
                             i, wq[i], exp[i]);
                end
                if (i > 0) begin
                    total++;
                    if (wcyc[i] - wcyc[i-1] != GUARD + 2) begin
                        bad++;
                        $display("FAIL tx_gap[%0d] got=%0d exp=%0d",
                                 i, wcyc[i] - wcyc[i-1], GUARD + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_rx_priority();
        int sc;
        logic [7:0] b2;
        do_reset();
        @(negedge clk);
        push_valid = 1;
        push_data = 8'h55;
        @(negedge clk);
        push_valid = 0;
        repeat (3) @(negedge clk);
        sc = cyc;
        rx_byte = 8'h7A;
        rx_pending = 1;
        tx_idle = 1;
        for (int i = 0; i < 50 && wq.size() < 1; i++)
            @(negedge clk);
        total += 2;
        if (rxq.size() !== 1) begin
            bad++;
            $display("FAIL rx_pulses got=%0d exp=1", rxq.size());
        end else begin
            total += 2;
            if (rxq[0] !== 8'h7A) begin
                bad++;
                $display("FAIL rx_data got=%h exp=7a", rxq[0]);
            end
            if (rxcyc[0] - sc != 2) begin
                bad++;
                $display("FAIL rx_lat got=%0d exp=2",
                         rxcyc[0] - sc);
            end
        end
        if (wq.size() !== 1) begin
            bad++;
            $display("FAIL rx_tx_count got=%0d exp=1", wq.size());
        end else begin
            total += 2;
            if (wq[0] !== 8'h55) begin
                bad++;
                $display("FAIL rx_tx_data got=%h exp=55", wq[0]);
            end
            if (rdcyc.size() == 0 || wcyc[0] <= rdcyc[0]) begin
                bad++;
                $display("FAIL rx_prio wr=%0d rd=%0d exp wr>rd",
                         wcyc[0],
                         rdcyc.size() ? rdcyc[0] : -1);
            end
        end
        b2 = 8'($urandom);
        rx_byte = b2;
        @(negedge clk);
        sc = cyc;
        rx_pending = 1;
        repeat (8) @(negedge clk);
        total += 2;
        if (rxq.size() !== 2 || rxq[1] !== b2) begin
            bad++;
            $display("FAIL rx_second n=%0d got=%h exp=%h",
                     rxq.size(), rx_data, b2);
        end
        if (rx_data !== b2) begin
            bad++;
            $display("FAIL rx_hold got=%h exp=%h", rx_data, b2);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp[3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp[i] = 8'($urandom);
            @(negedge clk);
            push_valid = 1;
            push_data = exp[i];
        end
        @(negedge clk);
        push_valid = 0;
        repeat (20) @(negedge clk);
        total += 4;
        if (wq.size() !== 0) begin
            bad++;
            $display("FAIL stall_wr got=%0d exp=0", wq.size());
        end
        if (busy !== 1) begin
            bad++; $display("FAIL stall_busy got=%0b exp=1", busy);
        end
        if (push_ready !== 1) begin
            bad++;
            $display("FAIL stall_ready got=%0b exp=1", push_ready);
        end
        if (rd !== 1 || addr !== A_STAT) begin
            bad++;
            $display("FAIL stall_poll rd=%0b addr=%h exp=1/%h",
                     rd, addr, A_STAT);
        end
        tx_idle = 1;
        for (int i = 0; i < 100 && wq.size() < 3; i++)
            @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wq.size() <= i || wq[i] !== exp[i]) begin
                bad++;
                $display("FAIL stall_drain[%0d] n=%0d exp=%h",
                         i, wq.size(), exp[i]);
            end
        end
    endtask

    task automatic test_overflow_and_full_pop();
        logic [7:0] b[17];
        logic [7:0] x;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            b[i] = 8'($urandom);
            @(negedge clk);
            if (i == 15) begin
                total++;
                if (push_ready !== 1) begin
                    bad++;
                    $display("FAIL ovf_ready15 got=%0b exp=1",
                             push_ready);
                end
            end
            if (i == 16) begin
                total++;
                if (push_ready !== 0) begin
                    bad++;
                    $display("FAIL ovf_ready16 got=%0b exp=0",
                             push_ready);
                end
            end
            push_valid = 1;
            push_data = b[i];
        end
        @(negedge clk);
        x = 8'($urandom);
        push_data = x;
        tx_idle = 1;
        for (int i = 0; i < 20 && !wr; i++)
            @(negedge clk);
        @(negedge clk);
        push_valid = 0;
        total++;
        if (push_ready !== 0) begin
            bad++;
            $display("FAIL fullpop_ready got=%0b exp=0", push_ready);
        end
        for (int i = 0; i < 500 && wq.size() < 17; i++)
            @(negedge clk);
        repeat (10) @(negedge clk);
        total++;
        if (wq.size() !== 17) begin
            bad++;
            $display("FAIL fullpop_count got=%0d exp=17", wq.size());
        end
        for (int i = 0; i < 17 && i < wq.size(); i++) begin
            total++;
            if (wq[i] !== (i < 16 ? b[i] : x)) begin
                bad++;
                $display("FAIL fullpop_seq[%0d] got=%h exp=%h",
                         i, wq[i], (i < 16 ? b[i] : x));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            push_valid = 1;
            push_data = 8'($urandom);
        end
        @(negedge clk);
        push_valid = 0;
        tx_idle = 1;
        for (int i = 0; i < 20 && !wr; i++)
            @(negedge clk);
        @(negedge clk);
        total++;
        if (rd !== 0 || wr !== 0) begin
            bad++;
            $display("FAIL mid_guard rd=%0b wr=%0b exp=0/0", rd, wr);
        end
        reset = 1;
        @(negedge clk);
        total += 3;
        if ({rd, wr, rx_valid, busy} !== 4'b0) begin
            bad++;
            $display("FAIL mid_strobes got=%b exp=0000",
                     {rd, wr, rx_valid, busy});
        end
        if (addr !== 0 || wdata !== 0) begin
            bad++;
            $display("FAIL mid_bus addr=%h wdata=%h exp=0",
                     addr, wdata);
        end
        if (push_ready !== 1) begin
            bad++;
            $display("FAIL mid_ready got=%0b exp=1", push_ready);
        end
        reset = 0;
        repeat (40) @(negedge clk);
        total++;
        if (wq.size() !== 1) begin
            bad++;
            $display("FAIL mid_writes got=%0d exp=1", wq.size());
        end
    endtask

    task automatic test_bus_rules();
        total++;
        if (bus_viol !== 0) begin
            bad++;
            $display("FAIL bus_rules got=%0d exp=0", bus_viol);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_rx_priority();
        test_stall();
        test_overflow_and_full_pop();
        test_reset_mid();
        test_bus_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
